// File: rtl/tone_pkg.sv
// Shared encodings, frequency table and half-period helper for the organ buzzer.
package tone_pkg;

    typedef enum logic [2:0] {REST, DO, RE, MI, FA, SOL, LA, TI} note_value_e;
    typedef enum logic [1:0] {OCT_LOW, OCT_MID, OCT_HIGH, OCT_RSV} octave_e;
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} tone_state_e;

    localparam int TONE_DIV_W = 18;

    localparam int unsigned F_DO  = 262;
    localparam int unsigned F_RE  = 294;
    localparam int unsigned F_MI  = 330;
    localparam int unsigned F_FA  = 349;
    localparam int unsigned F_SOL = 392;
    localparam int unsigned F_LA  = 440;
    localparam int unsigned F_TI  = 494;

    // Half-period in clocks; zero marks a rest or the reserved octave.
    function automatic logic [TONE_DIV_W-1:0] half_period(
        input logic [2:0]  value,
        input logic [1:0]  tone,
        input int unsigned clk_hz
    );
        int unsigned f;
        int unsigned mid;
        f = 0;
        case (value)
            DO:      f = F_DO;
            RE:      f = F_RE;
            MI:      f = F_MI;
            FA:      f = F_FA;
            SOL:     f = F_SOL;
            LA:      f = F_LA;
            TI:      f = F_TI;
            default: f = 0;
        endcase
        if (f == 0 || tone == OCT_RSV) begin
            return '0;
        end
        mid = clk_hz / (2 * f);
        case (tone)
            OCT_LOW:  mid = mid << 1;
            OCT_HIGH: mid = mid >> 1;
            default:  mid = mid;
        endcase
        return mid[TONE_DIV_W-1:0];
    endfunction

endpackage

// File: rtl/tone_lut.sv
// Combinational {tone,value} to reload-count (H-1) lookup, shared with the recorder.
module tone_lut
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          DIV_W  = 18
) (
    input  logic [4:0]       note,
    output logic [DIV_W-1:0] reload
);

    logic [TONE_DIV_W-1:0] h;

    always_comb begin
        h      = half_period(note[2:0], note[4:3], CLK_HZ);
        reload = (h == '0) ? '0 : DIV_W'(h - TONE_DIV_W'(1));
    end

endmodule

// File: rtl/tone_gen.sv
// Square-wave buzzer driver; note changes are applied only at half-period boundaries.
module tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          DIV_W  = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] value_in,
    input  logic [1:0] tone_in,
    input  logic       mute,
    output logic       buzz,
    output logic       busy,
    output logic [4:0] note_cur
);

    logic [2:0]       value_q;
    logic [1:0]       tone_q;
    logic             mute_q;
    logic [4:0]       req;
    logic             silent;
    logic [DIV_W-1:0] reload;
    logic [DIV_W-1:0] cnt;
    tone_state_e      state;

    assign req    = {tone_q, value_q};
    assign silent = (value_q == REST) || (tone_q == OCT_RSV) || mute_q;

    tone_lut #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) u_lut (
        .note   (req),
        .reload (reload)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            tone_q  <= '0;
            mute_q  <= 1'b0;
        end else begin
            value_q <= value_in;
            tone_q  <= tone_in;
            mute_q  <= mute;
        end
    end

    // Boundary at cnt == 0: either stop on a silent request or flip and reload with the current note.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            buzz     <= 1'b0;
            busy     <= 1'b0;
            note_cur <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!silent) begin
                        cnt      <= reload;
                        note_cur <= req;
                        buzz     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_HIGH;
                    end
                end
                S_HIGH, S_LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else if (silent) begin
                        cnt      <= '0;
                        buzz     <= 1'b0;
                        busy     <= 1'b0;
                        note_cur <= '0;
                        state    <= S_IDLE;
                    end else begin
                        cnt      <= reload;
                        note_cur <= req;
                        buzz     <= (state == S_LOW);
                        state    <= (state == S_HIGH) ? S_LOW : S_HIGH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: boundary-schedule reference model plus directed period/reset checks.
module tb_tone_gen;

    localparam int unsigned CLK_HZ = 52400;
    localparam int          MAXN   = 4000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic [2:0] value_in = '0;
    logic [1:0] tone_in  = '0;
    logic       mute     = 1'b0;
    logic       buzz;
    logic       busy;
    logic [4:0] note_cur;

    int checks = 0;
    int errors = 0;

    int sv [MAXN+1];
    int st [MAXN+1];
    int sm [MAXN+1];
    int eb [MAXN+1];
    int ey [MAXN+1];
    int en [MAXN+1];
    int n_cyc;

    int freq_tbl [8] = '{0, 262, 294, 330, 349, 392, 440, 494};

    tone_gen #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (18)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .tone_in  (tone_in),
        .mute     (mute),
        .buzz     (buzz),
        .busy     (busy),
        .note_cur (note_cur)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic [1:0] t, input logic m);
        value_in = v;
        tone_in  = t;
        mute     = m;
    endtask

    function automatic bit isSilent(input int v, input int t, input int m);
        return (v == 0) || (t == 3) || (m != 0);
    endfunction

    // Half-period in cycles straight from the musical definition.
    function automatic int halfLen(input int v, input int t);
        int hm;
        hm = int'(CLK_HZ) / (2 * freq_tbl[v]);
        if (t == 0) return hm * 2;
        if (t == 2) return hm / 2;
        return hm;
    endfunction

    task automatic clearTimeline();
        n_cyc = 0;
        sv[0] = 0;
        st[0] = 0;
        sm[0] = 0;
    endtask

    task automatic addSeg(input int v, input int t, input int m, input int len);
        for (int i = 0; i < len; i++) begin
            if (n_cyc < MAXN) begin
                n_cyc++;
                sv[n_cyc] = v;
                st[n_cyc] = t;
                sm[n_cyc] = m;
            end
        end
    endtask

    // Edge k acts on the input registered at edge k-1; boundaries are scheduled H edges apart.
    task automatic buildExpected();
        bit on;
        int lvl;
        int note;
        int next_b;
        on     = 1'b0;
        lvl    = 0;
        note   = 0;
        next_b = 0;
        for (int k = 1; k <= n_cyc; k++) begin
            if (!on) begin
                if (!isSilent(sv[k-1], st[k-1], sm[k-1])) begin
                    on     = 1'b1;
                    lvl    = 1;
                    note   = st[k-1] * 8 + sv[k-1];
                    next_b = k + halfLen(sv[k-1], st[k-1]);
                end
            end else if (k == next_b) begin
                if (isSilent(sv[k-1], st[k-1], sm[k-1])) begin
                    on   = 1'b0;
                    lvl  = 0;
                    note = 0;
                end else begin
                    lvl    = 1 - lvl;
                    note   = st[k-1] * 8 + sv[k-1];
                    next_b = k + halfLen(sv[k-1], st[k-1]);
                end
            end
            eb[k] = lvl;
            ey[k] = on ? 1 : 0;
            en[k] = note;
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(3'd0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_buzz", int'(buzz), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_note", int'(note_cur), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runTimeline();
        buildExpected();
        resetDut();
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge clk);
            applyStimulus(3'(sv[k]), 2'(st[k]), 1'(sm[k]));
            @(posedge clk);
            #1;
            checkOutput($sformatf("buzz@%0d", k), int'(buzz), eb[k]);
            checkOutput($sformatf("busy@%0d", k), int'(busy), ey[k]);
            checkOutput($sformatf("note@%0d", k), int'(note_cur), en[k]);
        end
    endtask

    // Rise latency and full period against hand-derived cycle counts.
    task automatic measurePeriod(input logic [2:0] v, input logic [1:0] t, input int exp_period);
        int lat;
        int per;
        bit prev;
        resetDut();
        @(negedge clk);
        applyStimulus(v, t, 1'b0);
        lat = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (buzz) begin
                lat = i;
                break;
            end
        end
        checkOutput($sformatf("rise_lat v%0d t%0d", v, t), lat, 2);
        per  = 0;
        prev = buzz;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk);
            #1;
            if (!prev && buzz) begin
                per = c;
                break;
            end
            prev = buzz;
        end
        checkOutput($sformatf("period v%0d t%0d", v, t), per, exp_period);
        checkOutput($sformatf("busy v%0d t%0d", v, t), int'(busy), 1);
        checkOutput($sformatf("note v%0d t%0d", v, t), int'(note_cur), int'({t, v}));
    endtask

    task automatic asyncResetCheck();
        int lat;
        resetDut();
        @(negedge clk);
        applyStimulus(3'd1, 2'd1, 1'b0);
        repeat (150) @(posedge clk);
        #1;
        checkOutput("busy_before_rst", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_buzz", int'(buzz), 0);
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_note", int'(note_cur), 0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (buzz) begin
                lat = i;
                break;
            end
        end
        checkOutput("restart_lat", lat, 2);
        checkOutput("restart_note", int'(note_cur), 9);
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        $display("[TB] starting tone_gen bench");

        measurePeriod(3'd1, 2'd1, 200);
        measurePeriod(3'd1, 2'd0, 400);
        measurePeriod(3'd1, 2'd2, 100);
        measurePeriod(3'd6, 2'd1, 118);
        asyncResetCheck();

        clearTimeline();
        addSeg(1, 1, 0, 450);
        addSeg(1, 0, 0, 500);
        addSeg(1, 2, 0, 200);
        addSeg(1, 1, 0, 230);
        addSeg(6, 1, 0, 300);
        addSeg(0, 1, 0, 300);
        addSeg(1, 1, 0, 130);
        addSeg(0, 1, 0, 200);
        addSeg(5, 3, 0, 100);
        addSeg(5, 1, 1, 100);
        addSeg(1, 1, 0, 50);
        addSeg(0, 1, 0, 20);
        addSeg(1, 1, 0, 200);
        runTimeline();

        for (int r = 0; r < 3; r++) begin
            clearTimeline();
            while (n_cyc < 2500) begin
                addSeg(int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2)),
                       int'($urandom_range(0, 7) == 0),
                       int'($urandom_range(1, 400)));
            end
            runTimeline();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_gen.md
# tone_gen

Buzzer driver for the electronic organ. It consumes the 3-bit note value and 2-bit octave code produced by the key front end or by the recorder's playback port, and converts them into a square wave for the piezo/speaker pin. Note changes take effect only at half-period boundaries, so the output never produces a runt pulse. It sits between the note source (keys or record/playback) and the board pin.

## Interface
Parameters:
- CLK_HZ, 50_000_000: system clock frequency; all half-period counts derive from it.
- DIV_W, 18: half-period counter width; must hold the largest count (low-octave C).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- value_in  in  3  0 = rest; 1..7 = do, re, mi, fa, sol, la, ti.
- tone_in  in  2  0 = low octave, 1 = mid octave, 2 = high octave, 3 = reserved (treated as rest).
- mute  in  1  1 = force silence (same handling as rest).
- buzz  out  1  square-wave output.
- busy  out  1  1 while a note is sounding.
- note_cur  out  5  {tone,value} currently sounding; 0 when silent.

## Operation
- Inputs are registered once (value_q, tone_q, mute_q). All decisions use the registered copies.
- Mid-octave frequencies (Hz): 262, 294, 330, 349, 392, 440, 494. Mid half-period H_mid = floor(CLK_HZ / (2*f)). Low octave H = H_mid << 1; high octave H = H_mid >> 1.
- Request is silent when value_q == 0, tone_q == 3, or mute_q == 1.
- FSM has three states:
  - IDLE: buzz = 0, busy = 0, note_cur = 0. A non-silent request loads cnt = H-1 and note_cur, sets buzz = 1, and moves to RUN.
  - RUN: cnt decrements each cycle. At cnt == 0, buzz toggles and the state then depends on the request:
    - If buzz was 1 and the request is now silent: buzz = 0, go to IDLE.
    - Otherwise reload cnt = H_new-1 with the H of the current request; note_cur updates to the current request.
    - A silent request while buzz is 0 at cnt == 0 goes straight to IDLE.
  - Mid-half changes are never applied before cnt reaches 0.
- Counter arithmetic is unsigned DIV_W bits and never wraps; the reload value is always ≥ 1.
- rst_n low at any time, including mid-note: immediately buzz = 0, busy = 0, note_cur = 0, cnt = 0, state IDLE, input registers cleared.

## Timing
- Reset values: buzz = 0, busy = 0, note_cur = 0.
- Start latency: request applied before edge t is sampled at t; buzz and busy rise after edge t+1.
- A steady note toggles buzz every H cycles, for a period of 2H cycles at a 50 % duty cycle.
- A note change lands at the first half-period boundary after sampling. The new half length is H_new from that boundary onward.
- Release: the high half completes, then buzz goes low and busy drops on the same edge. Release from the low half drops busy at the end of that low half.
- A rest lasting shorter than the remaining half-period is invisible; the note continues with the value sampled at the boundary.

## Structure
- Package tone_pkg holds:
  - the value and tone encodings (REST, DO..TI, OCT_LOW/MID/HIGH/RSV);
  - the seven mid-octave frequency constants;
  - a function half_period(value, tone, clk_hz) returning DIV_W bits.
- One sub-module, tone_lut: a combinational {tone,value} → H-1 lookup, kept separate so the recorder can reuse it.
- The FSM and counter live in tone_gen.

## Test plan
Run with CLK_HZ = 52400, which gives mid C H = 100 and mid A H = 59.
- Reset, then value = 1, tone = 1 held. Required: buzz rises 2 cycles after the apply edge, then toggles every 100 cycles; busy = 1; note_cur = 5'b01001.
- Same note with tone = 0, then tone = 2. Required: toggle spacing of 200 and 50 cycles respectively.
- Mid C sounding; switch to value = 6 at cycle 30 of a high half. Required: the high half still lasts 100 cycles, then all subsequent halves last 59 cycles.
- Mid C sounding; value = 0 applied during a high half. Required: the high half completes, then buzz = 0 and busy = 0. Rest applied in a low half ends busy at the end of that low half.
- tone = 3 or mute = 1 from IDLE with value = 5. Required: buzz stays 0 and busy stays 0.
- rst_n pulsed low mid-half (asynchronous, not clock-aligned). Required: buzz, busy and note_cur are 0 immediately; the note restarts 2 cycles after release.
